// File: rtl/thermo_pkg.sv
// Shared types and constants for the MAX6675-class thermocouple reader.
// Frame layout: bit 15 dummy sign, bits 14:3 temperature in 0.25 C, bit 2 open input.
package thermo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } rx_state_e;

  localparam int FRAME_W   = 16;
  localparam int FAULT_BIT = 2;
  localparam int SIGN_BIT  = 15;
  localparam int TEMP_MSB  = 14;
  localparam int TEMP_LSB  = 5;
  localparam int TEMP_W    = TEMP_MSB - TEMP_LSB + 1;

  localparam logic [7:0] TEMP_SAT = 8'hFF;

  function automatic logic [7:0] sat8(input logic [TEMP_W-1:0] v);
    return (|v[TEMP_W-1:8]) ? TEMP_SAT : v[7:0];
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI receive engine: CS setup, SCK generation and a 16-bit MSB-first shifter.
// Handshake: start_i is only accepted in IDLE; done_o is high for the single LATCH cycle, during which frame_o holds the completed frame.
module spi_frame_rx
  import thermo_pkg::*;
#(
  parameter int SCK_DIV = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               cs_n_o,
  output logic               done_o,
  output logic [FRAME_W-1:0] frame_o,
  output rx_state_e          state_o
);

  localparam int DIV_W = $clog2(SCK_DIV);

  rx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         fall_q, fall_d;
  logic               sck_q, sck_d;
  logic               cs_n_q, cs_n_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic               div_last;

  assign div_last = (div_q == DIV_W'(SCK_DIV - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    fall_d  = fall_q;
    sck_d   = sck_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        fall_d = '0;
        sck_d  = 1'b0;
        if (start_i) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_last) begin
          div_d = '0;
          sck_d = ~sck_q;
          // Rising edge samples MISO; the 16th falling edge ends the frame.
          if (!sck_q) begin
            shreg_d = {shreg_q[FRAME_W-2:0], miso_i};
          end else begin
            fall_d = fall_q + 1'b1;
            if (fall_q == 4'd15) state_d = ST_LATCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cs_n_d = !((state_d == ST_SETUP) || (state_d == ST_SHIFT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      fall_q  <= '0;
      sck_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      fall_q  <= fall_d;
      sck_q   <= sck_d;
      cs_n_q  <= cs_n_d;
      shreg_q <= shreg_d;
    end
  end

  assign sck_o   = sck_q;
  assign cs_n_o  = cs_n_q;
  assign done_o  = (state_q == ST_LATCH);
  assign frame_o = shreg_q;
  assign state_o = state_q;

endmodule

// File: rtl/thermo_reader.sv
// Periodic thermocouple poller: schedules frames, decodes them and
// produces a moving-average, 8-bit saturated temperature with a fault flag.
module thermo_reader
  import thermo_pkg::*;
#(
  parameter int SCK_DIV     = 16,
  parameter int POLL_CYCLES = 25_000_000,
  parameter int AVG_LOG2    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       spi_miso_i,
  output logic       spi_sck_o,
  output logic       spi_cs_n_o,
  output logic [7:0] temp_o,
  output logic       temp_valid_o,
  output logic       fault_o,
  output logic       busy_o
);

  localparam int POLL_W = $clog2(POLL_CYCLES + 1);
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SUM_W  = TEMP_W + AVG_LOG2;

  logic [POLL_W-1:0]  poll_q, poll_d;
  logic               start;
  rx_state_e          rx_state;
  logic               rx_done;
  logic [FRAME_W-1:0] frame;

  logic [TEMP_W-1:0]  hist_q [DEPTH];
  logic [PTR_W-1:0]   ptr_q;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               prefill_q;
  logic [7:0]         temp_q;
  logic               valid_q;
  logic               fault_q;

  logic [TEMP_W-1:0]  t_val;
  logic [TEMP_W-1:0]  avg;
  logic               bad;

  spi_frame_rx #(.SCK_DIV(SCK_DIV)) u_rx (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start),
    .miso_i  (spi_miso_i),
    .sck_o   (spi_sck_o),
    .cs_n_o  (spi_cs_n_o),
    .done_o  (rx_done),
    .frame_o (frame),
    .state_o (rx_state)
  );

  // The poll counter only advances while idle, so the period includes the frame itself.
  always_comb begin
    poll_d = poll_q;
    start  = 1'b0;
    if (!en_i) begin
      poll_d = '0;
    end else if (rx_state == ST_IDLE) begin
      if (poll_q == POLL_W'(POLL_CYCLES - 1)) begin
        start  = 1'b1;
        poll_d = '0;
      end else begin
        poll_d = poll_q + 1'b1;
      end
    end
  end

  always_comb begin
    t_val = frame[TEMP_MSB:TEMP_LSB];
    bad   = frame[FAULT_BIT] | frame[SIGN_BIT];
    if (prefill_q) sum_d = SUM_W'(t_val) << AVG_LOG2;
    else           sum_d = sum_q + SUM_W'(t_val) - SUM_W'(hist_q[ptr_q]);
    avg = TEMP_W'(sum_d >> AVG_LOG2);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_q    <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      prefill_q <= 1'b1;
      temp_q    <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      poll_q  <= poll_d;
      valid_q <= 1'b0;
      if (rx_done) begin
        if (bad) begin
          fault_q <= 1'b1;
        end else begin
          fault_q   <= 1'b0;
          valid_q   <= 1'b1;
          temp_q    <= sat8(avg);
          sum_q     <= sum_d;
          prefill_q <= 1'b0;
          if (prefill_q) begin
            for (int i = 0; i < DEPTH; i++) hist_q[i] <= t_val;
          end else begin
            hist_q[ptr_q] <= t_val;
            ptr_q <= (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
          end
        end
      end
    end
  end

  assign temp_o       = temp_q;
  assign temp_valid_o = valid_q;
  assign fault_o      = fault_q;
  assign busy_o       = ~spi_cs_n_o;

endmodule

// File: tb/tb_thermo_reader.sv
// Directed bench: two readers (4-deep and unfiltered) in lockstep against a
// converter model, checked against hand-computed temperatures.
module tb_thermo_reader;

  localparam int SCK_DIV = 2;
  localparam int POLL    = 100;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic en_i = 1'b0;
  logic spi_miso = 1'b0;

  logic       sck_a, cs_n_a, valid_a, fault_a, busy_a;
  logic [7:0] temp_a;
  logic       sck_b, cs_n_b, valid_b, fault_b, busy_b;
  logic [7:0] temp_b;

  always #5 clk = ~clk;

  thermo_reader #(.SCK_DIV(SCK_DIV), .POLL_CYCLES(POLL), .AVG_LOG2(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .spi_miso_i(spi_miso),
    .spi_sck_o(sck_a), .spi_cs_n_o(cs_n_a), .temp_o(temp_a),
    .temp_valid_o(valid_a), .fault_o(fault_a), .busy_o(busy_a)
  );

  thermo_reader #(.SCK_DIV(SCK_DIV), .POLL_CYCLES(POLL), .AVG_LOG2(0)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .spi_miso_i(spi_miso),
    .spi_sck_o(sck_b), .spi_cs_n_o(cs_n_b), .temp_o(temp_b),
    .temp_valid_o(valid_b), .fault_o(fault_b), .busy_o(busy_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Converter model and frame monitor, all updated away from the active edge.
  logic [15:0] model_frame = 16'h0C80;
  int   cs_low_cnt = 0, rise_cnt = 0, valid_cnt = 0, frames_done = 0;
  logic cs_prev = 1'b1, sck_prev = 1'b0;

  always @(negedge clk) begin
    if (!cs_n_a && cs_prev) begin
      cs_low_cnt = 0;
      rise_cnt   = 0;
      valid_cnt  = 0;
    end
    if (!cs_n_a) begin
      cs_low_cnt++;
      if (sck_a && !sck_prev) rise_cnt++;
    end
    if (cs_n_a && !cs_prev) frames_done++;
    if (valid_a) valid_cnt++;
    cs_prev  = cs_n_a;
    sck_prev = sck_a;
    spi_miso = (!cs_n_a && rise_cnt < 16) ? model_frame[4'(15 - rise_cnt)] : 1'b0;
  end

  task automatic run_frame(input logic [15:0] f);
    int fd;
    int n;
    model_frame = f;
    fd = frames_done;
    n  = 0;
    while (frames_done == fd && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (frames_done == fd) chk("frame_timeout", 16'd0, 16'd1);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] frame;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic        exp_fault;
    int          exp_valid;
  } vec_t;

  vec_t vecs[14] = '{
    '{16'h0C80, 8'h64, 8'h64, 1'b0, 1},
    '{16'h0C80, 8'h64, 8'h64, 1'b0, 1},
    '{16'h0C80, 8'h64, 8'h64, 1'b0, 1},
    '{16'h0C80, 8'h64, 8'h64, 1'b0, 1},
    '{16'h0640, 8'h57, 8'h32, 1'b0, 1},
    '{16'h0640, 8'h4B, 8'h32, 1'b0, 1},
    '{16'h0640, 8'h3E, 8'h32, 1'b0, 1},
    '{16'h0640, 8'h32, 8'h32, 1'b0, 1},
    '{16'h0640, 8'h32, 8'h32, 1'b0, 1},
    '{16'h0004, 8'h32, 8'h32, 1'b1, 0},
    '{16'h8C80, 8'h32, 8'h32, 1'b1, 0},
    '{16'h0C80, 8'h3E, 8'h64, 1'b0, 1},
    '{16'h7FF8, 8'hFF, 8'hFF, 1'b0, 1},
    '{16'h0500, 8'hFF, 8'h28, 1'b0, 1}
  };

  initial begin
    int n;
    int lows;
    // Clock/reset
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 16'(cs_n_a), 16'd1);
    chk("rst_sck", 16'(sck_a), 16'd0);
    chk("rst_temp", 16'(temp_a), 16'd0);
    chk("rst_valid", 16'(valid_a), 16'd0);
    chk("rst_fault", 16'(fault_a), 16'd0);
    chk("rst_busy", 16'(busy_a), 16'd0);

    rst_i = 1'b0;
    en_i  = 1'b1;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (!cs_n_a) break;
    end
    chk("first_cs_fall_cycles", 16'(n), 16'(POLL));
    chk("busy_in_frame", 16'(busy_a), 16'd1);

    foreach (vecs[i]) begin
      run_frame(vecs[i].frame);
      chk($sformatf("cs_low_cycles[%0d]", i), 16'(cs_low_cnt), 16'(33 * SCK_DIV));
      chk($sformatf("sck_rises[%0d]", i), 16'(rise_cnt), 16'd16);
      chk($sformatf("temp_avg4[%0d]", i), 16'(temp_a), 16'(vecs[i].exp_a));
      chk($sformatf("temp_avg1[%0d]", i), 16'(temp_b), 16'(vecs[i].exp_b));
      chk($sformatf("fault[%0d]", i), 16'(fault_a), 16'(vecs[i].exp_fault));
      chk($sformatf("valid_pulses[%0d]", i), 16'(valid_cnt), 16'(vecs[i].exp_valid));
    end
    chk("lockstep_cs", 16'(cs_n_b), 16'(cs_n_a));

    // Reset in the middle of SHIFT
    n = 0;
    while (cs_n_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cs_fall_before_reset", 16'(cs_n_a), 16'd0);
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cs_n", 16'(cs_n_a), 16'd1);
    chk("midrst_sck", 16'(sck_a), 16'd0);
    chk("midrst_temp", 16'(temp_a), 16'd0);
    chk("midrst_valid", 16'(valid_a), 16'd0);
    @(negedge clk);
    rst_i = 1'b0;
    en_i  = 1'b0;
    lows = 0;
    repeat (500) begin
      @(negedge clk);
      if (!cs_n_a) lows++;
    end
    chk("cs_low_while_disabled", 16'(lows), 16'd0);

    // History must be refilled from scratch after reset
    en_i = 1'b1;
    run_frame(16'h0640);
    chk("prefill_after_reset", 16'(temp_a), 16'h32);
    chk("valid_after_reset", 16'(valid_cnt), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/thermo_reader.md
# thermo_reader

Periodic SPI reader for a MAX6675-class thermocouple converter. It produces the 8-bit °C temperature word consumed by the heater on/off PWM controller's `temp_i` input. It polls the converter at a fixed interval, decodes the 16-bit frame, filters the result with a power-of-two moving average, saturates it to 8 bits, and flags open-thermocouple faults. It sits between the board's thermocouple converter pins and the temperature controller, all in the 100 MHz `clk_i` domain.

## Interface
- `SCK_DIV`, default 16: `clk_i` cycles per SCK half-period (3.125 MHz at 100 MHz). Must be ≥2.
- `POLL_CYCLES`, default 25_000_000: cycles between frame starts (250 ms, which covers the 220 ms conversion time).
- `AVG_LOG2`, default 2: moving-average depth is 2^AVG_LOG2, range 0–3; 0 disables averaging.
- `clk_i`  in  1  system clock; one clock domain only.
- `rst_i`  in  1  reset, synchronous, active-high.
- `en_i`  in  1  polling enable.
- `spi_miso_i`  in  1  converter SO; treated as already synchronised.
- `spi_sck_o`  out  1  SPI clock; idles low.
- `spi_cs_n_o`  out  1  converter chip select, active low.
- `temp_o`  out  8  filtered temperature in whole °C, saturated to 255.
- `temp_valid_o`  out  1  one-cycle strobe: `temp_o` has been updated.
- `fault_o`  out  1  last frame was faulty (open thermocouple or bad frame).
- `busy_o`  out  1  a frame is in progress (`spi_cs_n_o` low).

## Operation
- States:
  - IDLE: CS high, SCK low.
  - SETUP: CS low for SCK_DIV cycles (tCSS).
  - SHIFT: 16 SCK periods.
  - LATCH: one cycle, CS high.
  - LATCH always returns to IDLE.
- Poll counter:
  - Counts only while `en_i`=1 and the FSM is in IDLE.
  - It is cleared when `en_i`=0.
  - When it reaches POLL_CYCLES-1, the FSM goes IDLE→SETUP and the counter clears.
  - The first frame after reset therefore starts POLL_CYCLES cycles after `en_i` is seen high.
- SHIFT:
  - SCK toggles every SCK_DIV cycles, starting low.
  - MISO is sampled on each SCK rising edge, MSB first, into frame bits f[15:0].
  - After the 16th falling edge the FSM enters LATCH.
- Deasserting `en_i` mid-frame does not abort the frame; it completes.
- Decode in LATCH:
  - Fault if f[2]=1 (open input) or f[15]=1 (dummy sign bit must be 0).
  - Otherwise the integer temperature is t = f[14:5], 10 bits (quarter-degree bits dropped).
- Good frame:
  - t is pushed into the 2^AVG_LOG2 history window.
  - The running sum (width 10+AVG_LOG2) is updated as sum + t − oldest.
  - avg = sum >> AVG_LOG2, truncating.
  - `temp_o` = avg>255 ? 8'hFF : avg[7:0].
  - `fault_o` clears to 0.
  - `temp_valid_o` pulses.
- First good frame after reset: every history slot is prefilled with t, so the first output equals t.
- Fault frame: history, sum and `temp_o` are held, `fault_o` is set to 1, and no `temp_valid_o` strobe is issued.

## Timing
- Reset values: `spi_cs_n_o`=1, `spi_sck_o`=0, `temp_o`=0, `temp_valid_o`=0, `fault_o`=0, `busy_o`=0. History and sum are cleared and the prefill flag is set.
- Reset asserted mid-frame: the frame is aborted, and CS is high and SCK low on the cycle after `rst_i` is sampled.
- CS low window is exactly 33·SCK_DIV cycles: SETUP plus 32 half-periods.
- `spi_sck_o` shows exactly 16 rising edges per frame.
- Frame period is exactly POLL_CYCLES + 33·SCK_DIV + 1 cycles with `en_i` held high.
- `temp_o`, `fault_o` and `temp_valid_o` are all registered:
  - They update on the clock edge that ends LATCH.
  - `temp_valid_o` is high for exactly one cycle, which is the first IDLE cycle.
- `busy_o` equals ~`spi_cs_n_o`.
- All outputs come from registers; no combinational path from inputs to outputs.

## Structure
- Package `thermo_pkg` holds:
  - FSM state enum (IDLE/SETUP/SHIFT/LATCH).
  - FRAME_W=16.
  - Bit indices: FAULT_BIT=2, SIGN_BIT=15, TEMP_MSB=14, TEMP_LSB=5.
  - TEMP_SAT=8'hFF.
- Sub-module `spi_frame_rx`: SCK divider, CS sequencing and the 16-bit shifter. It has a start/done handshake and a `frame[15:0]` output.
- Top level holds the poll counter, decode, moving-average window and output registers.

## Test plan
Bench parameters: SCK_DIV=2, POLL_CYCLES=100, AVG_LOG2=2, unless stated otherwise.
- Reset then `en_i`=1 → all reset values hold, and `spi_cs_n_o` stays high for exactly 100 cycles before falling.
- Converter model returns 0x0C80 → CS low for 66 cycles with 16 SCK rising edges; `temp_o`=0x64 (prefill); one `temp_valid_o` pulse.
- Four frames of 0x0C80, then 0x0640 → fifth output `temp_o`=0x57 ((3·100+50)/4=87); four more frames of 0x0640 → `temp_o` settles at 0x32.
- Frame 0x0004 after `temp_o`=0x64 → `fault_o`=1, `temp_o` stays 0x64, no strobe; next 0x0C80 frame → `fault_o`=0 and a strobe.
- Frame 0x7FF8 (1023 °C) → `temp_o`=0xFF; with AVG_LOG2=0, frame 0x0500 → `temp_o`=0x28 exactly.
- `rst_i` pulsed during SHIFT → next cycle CS=1, SCK=0, `temp_o`=0; then `en_i`=0 for 500 cycles → CS never falls.
